// File: rtl/dir_scancode_encoder.sv
// Emits PS/2 set-2 make/break byte sequences for four direction keys over a
// valid/ready byte stream, one sequence per change of a key level.
module dir_scancode_encoder #(
   parameter int unsigned EXTENDED   = 1,
   parameter int unsigned GAP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       right,
   input  logic       left,
   input  logic       down,
   input  logic       dataReady,
   output logic [7:0] dataOut,
   output logic       dataValid,
   output logic       busy
);

   localparam int unsigned CntW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [2:0] {StIdle, StPrefix, StBrk, StCode, StGap} state_e;

   state_e          state_q, state_d;
   state_e          after_q, after_d;
   state_e          succ;
   logic [3:0]      reported_q, reported_d;
   logic [1:0]      key_q, key_d;
   logic            make_q, make_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [7:0]      out_q, out_d;
   logic [7:0]      code;
   logic [3:0]      keys;
   logic [3:0]      pending;
   logic            accept;

   // Bit order matches key priority: bit 3 (up) wins.
   assign keys    = {up, right, left, down};
   assign pending = keys ^ reported_q;
   assign accept  = dataValid && dataReady;

   always_comb begin
      case (key_d)
         2'd3:    code = 8'h75;
         2'd2:    code = 8'h74;
         2'd1:    code = 8'h6B;
         default: code = 8'h72;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      after_d    = after_q;
      reported_d = reported_q;
      key_d      = key_q;
      make_d     = make_q;
      cnt_d      = cnt_q;
      succ       = StIdle;
      case (state_q)
         StIdle: begin
            if (pending != 4'b0000) begin
               if (pending[3])      key_d = 2'd3;
               else if (pending[2]) key_d = 2'd2;
               else if (pending[1]) key_d = 2'd1;
               else                 key_d = 2'd0;
               make_d = keys[key_d];
               if (EXTENDED != 0) state_d = StPrefix;
               else if (!make_d)  state_d = StBrk;
               else               state_d = StCode;
            end
         end
         StPrefix: succ = make_q ? StCode : StBrk;
         StBrk:    succ = StCode;
         StCode: begin
            succ = StIdle;
            if (accept) reported_d[key_q] = make_q;
         end
         StGap: begin
            if (cnt_q == CntW'(GAP_CYCLES - 1)) state_d = after_q;
            else                                cnt_d   = cnt_q + CntW'(1);
         end
         default: state_d = StIdle;
      endcase
      // Every accepted byte detours through the gap when one is configured.
      if (accept) begin
         if (GAP_CYCLES > 0) begin
            state_d = StGap;
            after_d = succ;
            cnt_d   = '0;
         end else begin
            state_d = succ;
         end
      end
   end

   always_comb begin
      out_d = out_q;
      case (state_d)
         StPrefix: out_d = 8'hE0;
         StBrk:    out_d = 8'hF0;
         StCode:   out_d = code;
         default:  out_d = out_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         after_q    <= StIdle;
         reported_q <= 4'b0000;
         key_q      <= 2'd0;
         make_q     <= 1'b0;
         cnt_q      <= '0;
         out_q      <= 8'h00;
      end else begin
         state_q    <= state_d;
         after_q    <= after_d;
         reported_q <= reported_d;
         key_q      <= key_d;
         make_q     <= make_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
      end
   end

   assign dataOut   = out_q;
   assign dataValid = (state_q == StPrefix) || (state_q == StBrk) || (state_q == StCode);
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dir_scancode_encoder.sv
// Bench for dir_scancode_encoder: three configurations, directed key stimulus,
// per-instance byte scoreboards plus cycle-exact valid/busy/dataOut checks.
module tb_dir_scancode_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   logic       a_rst, b_rst, c_rst;
   logic [3:0] a_keys, b_keys, c_keys;
   logic       a_ready, b_ready, c_ready;
   logic [7:0] a_out, b_out, c_out;
   logic       a_valid, b_valid, c_valid;
   logic       a_busy, b_busy, c_busy;

   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] qc[$];

   dir_scancode_encoder #(.EXTENDED(1), .GAP_CYCLES(0)) u_a (
      .clk(clk), .reset(a_rst), .up(a_keys[3]), .right(a_keys[2]), .left(a_keys[1]),
      .down(a_keys[0]), .dataReady(a_ready), .dataOut(a_out), .dataValid(a_valid),
      .busy(a_busy));

   dir_scancode_encoder #(.EXTENDED(1), .GAP_CYCLES(4)) u_b (
      .clk(clk), .reset(b_rst), .up(b_keys[3]), .right(b_keys[2]), .left(b_keys[1]),
      .down(b_keys[0]), .dataReady(b_ready), .dataOut(b_out), .dataValid(b_valid),
      .busy(b_busy));

   dir_scancode_encoder #(.EXTENDED(0), .GAP_CYCLES(0)) u_c (
      .clk(clk), .reset(c_rst), .up(c_keys[3]), .right(c_keys[2]), .left(c_keys[1]),
      .down(c_keys[0]), .dataReady(c_ready), .dataOut(c_out), .dataValid(c_valid),
      .busy(c_busy));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ca(input string name, input logic v, input logic b, input logic [7:0] o);
      check({name, ".valid"}, 32'(a_valid), 32'(v));
      check({name, ".busy"}, 32'(a_busy), 32'(b));
      check({name, ".out"}, 32'(a_out), 32'(o));
   endtask

   task automatic cb(input string name, input logic v, input logic b, input logic [7:0] o);
      check({name, ".valid"}, 32'(b_valid), 32'(v));
      check({name, ".busy"}, 32'(b_busy), 32'(b));
      check({name, ".out"}, 32'(b_out), 32'(o));
   endtask

   task automatic cc(input string name, input logic v, input logic b, input logic [7:0] o);
      check({name, ".valid"}, 32'(c_valid), 32'(v));
      check({name, ".busy"}, 32'(c_busy), 32'(b));
      check({name, ".out"}, 32'(c_out), 32'(o));
   endtask

   // Scoreboard monitors: every transferred byte must match the next queued one.
   always @(negedge clk) begin
      if (!a_rst && a_valid && a_ready) begin
         if (qa.size() == 0) check("a_unexpected_byte", 32'(a_out), 32'h1FF);
         else                check("a_byte", 32'(a_out), 32'(qa.pop_front()));
      end
      if (!b_rst && b_valid && b_ready) begin
         if (qb.size() == 0) check("b_unexpected_byte", 32'(b_out), 32'h1FF);
         else                check("b_byte", 32'(b_out), 32'(qb.pop_front()));
      end
      if (!c_rst && c_valid && c_ready) begin
         if (qc.size() == 0) check("c_unexpected_byte", 32'(c_out), 32'h1FF);
         else                check("c_byte", 32'(c_out), 32'(qc.pop_front()));
      end
   end

   initial begin
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      a_keys = '0;  b_keys = '0;  c_keys = '0;
      a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
      step();
      step();
      ca("a_reset", 1'b0, 1'b0, 8'h00);
      cb("b_reset", 1'b0, 1'b0, 8'h00);
      cc("c_reset", 1'b0, 1'b0, 8'h00);
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

      // A: EXTENDED=1, GAP=0. Make up, then break up.
      a_keys[3] = 1'b1;
      qa.push_back(8'hE0); qa.push_back(8'h75);
      step(); ca("a_make_e0", 1'b1, 1'b1, 8'hE0);
      step(); ca("a_make_75", 1'b1, 1'b1, 8'h75);
      step(); ca("a_make_idle", 1'b0, 1'b0, 8'h75);
      a_keys[3] = 1'b0;
      qa.push_back(8'hE0); qa.push_back(8'hF0); qa.push_back(8'h75);
      step(); ca("a_brk_e0", 1'b1, 1'b1, 8'hE0);
      step(); ca("a_brk_f0", 1'b1, 1'b1, 8'hF0);
      step(); ca("a_brk_75", 1'b1, 1'b1, 8'h75);
      step(); ca("a_brk_idle", 1'b0, 1'b0, 8'h75);
      step(); ca("a_brk_stays_idle", 1'b0, 1'b0, 8'h75);

      // Simultaneous right and down: right first, one idle cycle between.
      a_keys[2] = 1'b1; a_keys[0] = 1'b1;
      qa.push_back(8'hE0); qa.push_back(8'h74); qa.push_back(8'hE0); qa.push_back(8'h72);
      step(); ca("a_sim_e0", 1'b1, 1'b1, 8'hE0);
      step(); ca("a_sim_74", 1'b1, 1'b1, 8'h74);
      step(); ca("a_sim_gap", 1'b0, 1'b0, 8'h74);
      step(); ca("a_sim_e0b", 1'b1, 1'b1, 8'hE0);
      step(); ca("a_sim_72", 1'b1, 1'b1, 8'h72);
      step(); ca("a_sim_idle", 1'b0, 1'b0, 8'h72);

      // Backpressure: output must hold while ready is low.
      a_ready = 1'b0;
      a_keys[3] = 1'b1;
      qa.push_back(8'hE0); qa.push_back(8'h75);
      step(); ca("a_bp_first", 1'b1, 1'b1, 8'hE0);
      for (int i = 0; i < 5; i++) begin
         step(); ca("a_bp_hold", 1'b1, 1'b1, 8'hE0);
      end
      a_ready = 1'b1;
      step(); ca("a_bp_75", 1'b1, 1'b1, 8'h75);
      step(); ca("a_bp_idle", 1'b0, 1'b0, 8'h75);
      a_keys[3] = 1'b0;
      qa.push_back(8'hE0); qa.push_back(8'hF0); qa.push_back(8'h75);
      for (int i = 0; i < 4; i++) step();
      ca("a_final", 1'b0, 1'b0, 8'h75);

      // B: EXTENDED=1, GAP=4. Make left with gaps after each byte.
      b_keys[1] = 1'b1;
      qb.push_back(8'hE0); qb.push_back(8'h6B);
      step(); cb("b_e0", 1'b1, 1'b1, 8'hE0);
      for (int i = 0; i < 4; i++) begin
         step(); cb("b_gap1", 1'b0, 1'b1, 8'hE0);
      end
      step(); cb("b_6b", 1'b1, 1'b1, 8'h6B);
      for (int i = 0; i < 4; i++) begin
         step(); cb("b_gap2", 1'b0, 1'b1, 8'h6B);
      end
      step(); cb("b_idle", 1'b0, 1'b0, 8'h6B);

      // Make up, then break left aborted by reset with up still held.
      b_keys[3] = 1'b1;
      qb.push_back(8'hE0); qb.push_back(8'h75);
      for (int i = 0; i < 11; i++) step();
      cb("b_up_idle", 1'b0, 1'b0, 8'h75);
      b_keys[1] = 1'b0;
      qb.push_back(8'hE0);
      step(); cb("b_brk_e0", 1'b1, 1'b1, 8'hE0);
      step(); cb("b_brk_gap", 1'b0, 1'b1, 8'hE0);
      b_rst = 1'b1;
      step(); cb("b_rst_abort", 1'b0, 1'b0, 8'h00);
      b_rst = 1'b0;
      qb.push_back(8'hE0); qb.push_back(8'h75);
      step(); cb("b_rerep_e0", 1'b1, 1'b1, 8'hE0);
      for (int i = 0; i < 5; i++) step();
      cb("b_rerep_75", 1'b1, 1'b1, 8'h75);
      for (int i = 0; i < 5; i++) step();
      cb("b_rerep_idle", 1'b0, 1'b0, 8'h75);

      // C: EXTENDED=0. One-cycle pulse in IDLE, then a pulse hidden by busy.
      c_keys[0] = 1'b1;
      qc.push_back(8'h72); qc.push_back(8'hF0); qc.push_back(8'h72);
      step(); cc("c_make_72", 1'b1, 1'b1, 8'h72);
      c_keys[0] = 1'b0;
      step(); cc("c_idle1", 1'b0, 1'b0, 8'h72);
      step(); cc("c_brk_f0", 1'b1, 1'b1, 8'hF0);
      step(); cc("c_brk_72", 1'b1, 1'b1, 8'h72);
      step(); cc("c_idle2", 1'b0, 1'b0, 8'h72);
      c_keys[3] = 1'b1;
      qc.push_back(8'h75);
      step(); cc("c_up_75", 1'b1, 1'b1, 8'h75);
      c_keys[0] = 1'b1;
      step(); cc("c_pulse_busy", 1'b0, 1'b0, 8'h75);
      c_keys[0] = 1'b0;
      step(); cc("c_no_report1", 1'b0, 1'b0, 8'h75);
      step(); cc("c_no_report2", 1'b0, 1'b0, 8'h75);

      for (int i = 0; i < 4; i++) step();
      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);
      check("c_queue_drained", 32'(qc.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
